// File: rtl/spi_fram_responder_if.sv
// SPI bus between a master and the FRAM-style responder.
// Signal names follow the pin names used on the board.
interface spi_fram_responder_if;
   logic CS_N;
   logic CLK;
   logic MOSI;
   logic MISO;
   logic miso_oe;

   modport master (output CS_N, output CLK, output MOSI, input MISO, input miso_oe);
   modport slave  (input CS_N, input CLK, input MOSI, output MISO, output miso_oe);
endinterface

// File: rtl/spi_fram_responder.sv
// SPI mode-0 responder emulating a small byte-addressed FRAM.
// Supports READ (0x03), WRITE (0x02), RDSR (0x05), WREN (0x06) and WRDI (0x04).
// All SPI pins are oversampled by clk; the SPI clock must be at most clk/8.
module spi_fram_responder #(
   parameter int ADDR_BITS = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   spi_fram_responder_if.slave   spi,
   output logic                  wel,
   output logic                  busy
);

   localparam int DEPTH = 1 << ADDR_BITS;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] OPCODE  = 3'd1;
   localparam logic [2:0] ADDR_HI = 3'd2;
   localparam logic [2:0] ADDR_LO = 3'd3;
   localparam logic [2:0] DATA_RD = 3'd4;
   localparam logic [2:0] DATA_WR = 3'd5;
   localparam logic [2:0] STATUS  = 3'd6;
   localparam logic [2:0] IGNORE  = 3'd7;

   localparam logic [1:0] PEND_NONE = 2'd0;
   localparam logic [1:0] PEND_WREN = 2'd1;
   localparam logic [1:0] PEND_WRDI = 2'd2;

   logic [1:0]           cs_sync, sclk_sync, mosi_sync;
   logic                 cs_q, sclk_q;
   logic [1:0]           sync_ok;
   logic                 armed;
   logic                 cs_s, sclk_s, mosi_s;
   logic                 cs_fall, cs_rise, sclk_rise, sclk_fall;

   logic [2:0]           state;
   logic [2:0]           bit_cnt;
   logic [6:0]           rx_sr;
   logic [7:0]           tx_sr;
   logic                 miso_r;
   logic [ADDR_BITS-1:0] addr;
   logic [1:0]           pend;
   logic                 extra;
   logic                 is_read;

   logic [7:0]           mem [DEPTH];
   logic [7:0]           rd_q;

   logic [7:0]           rx_byte;
   logic [7:0]           load_byte;
   logic [ADDR_BITS-1:0] addr_shift;
   logic                 byte_done;
   logic                 mem_re, mem_we;
   logic [ADDR_BITS-1:0] mem_raddr;

   assign cs_s      = cs_sync[1];
   assign sclk_s    = sclk_sync[1];
   assign mosi_s    = mosi_sync[1];
   // A fall seen before the synchronizer has observed CS_N high after reset
   // is the tail of an interrupted frame, not the start of a new one.
   assign cs_fall   = cs_q & ~cs_s & armed;
   assign cs_rise   = ~cs_q & cs_s;
   assign sclk_rise = ~sclk_q & sclk_s;
   assign sclk_fall = sclk_q & ~sclk_s;

   assign rx_byte    = {rx_sr, mosi_s};
   assign addr_shift = {addr[ADDR_BITS-2:0], mosi_s};
   assign byte_done  = sclk_rise & (bit_cnt == 3'd7);
   assign load_byte  = (state == DATA_RD) ? rd_q : {6'b0, wel, 1'b0};

   assign spi.MISO    = miso_r;
   assign spi.miso_oe = ~cs_s;
   assign busy        = (state != IDLE);

   // Synchronize the SPI pins and arm frame start once CS_N is seen idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: CS_N stages reset to the deselected level so miso_oe is low
         // in reset and no phantom edge appears when reset is released.
         cs_sync   <= 2'b11;
         sclk_sync <= 2'b00;
         mosi_sync <= 2'b00;
         cs_q      <= 1'b1;
         sclk_q    <= 1'b0;
         sync_ok   <= 2'b00;
         armed     <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[0], spi.CS_N};
         sclk_sync <= {sclk_sync[0], spi.CLK};
         mosi_sync <= {mosi_sync[0], spi.MOSI};
         cs_q      <= cs_s;
         sclk_q    <= sclk_s;
         sync_ok   <= {sync_ok[0], 1'b1};
         armed     <= armed | (sync_ok[1] & cs_s);
      end
   end

   // Memory port strobes: first read after the address, prefetch per byte, writes.
   always_comb begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_raddr = addr;
      if (!rst && !cs_rise && byte_done) begin
         if (state == ADDR_LO && is_read) begin
            mem_re    = 1'b1;
            mem_raddr = addr_shift;
         end
         if (state == DATA_RD) begin
            mem_re    = 1'b1;
            mem_raddr = addr + ADDR_BITS'(1);
         end
         if (state == DATA_WR && wel) begin
            mem_we = 1'b1;
         end
      end
   end

   // Byte array with a registered read port.
   // NOTE: the array is deliberately not reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[addr] <= rx_byte;
      end
      if (mem_re) begin
         rd_q <= mem[mem_raddr];
      end
   end

   // Transaction FSM, shift registers and write-enable latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= 3'd0;
         rx_sr   <= 7'd0;
         tx_sr   <= 8'd0;
         miso_r  <= 1'b0;
         addr    <= '0;
         pend    <= PEND_NONE;
         extra   <= 1'b0;
         is_read <= 1'b0;
         wel     <= 1'b0;
      end else if (cs_rise) begin
         if (state == IGNORE && !extra) begin
            if (pend == PEND_WREN) wel <= 1'b1;
            if (pend == PEND_WRDI) wel <= 1'b0;
         end
         if (state == DATA_WR) wel <= 1'b0;
         state   <= IDLE;
         bit_cnt <= 3'd0;
      end else if (cs_fall && state == IDLE) begin
         state   <= OPCODE;
         bit_cnt <= 3'd0;
         miso_r  <= 1'b0;
         tx_sr   <= 8'd0;
         pend    <= PEND_NONE;
         extra   <= 1'b0;
         is_read <= 1'b0;
      end else if (state != IDLE) begin
         if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            rx_sr   <= rx_byte[6:0];
            case (state)
               OPCODE: begin
                  if (bit_cnt == 3'd7) begin
                     case (rx_byte)
                        8'h03: begin state <= ADDR_HI; is_read <= 1'b1; end
                        8'h02: state <= ADDR_HI;
                        8'h05: state <= STATUS;
                        8'h06: begin state <= IGNORE; pend <= PEND_WREN; end
                        8'h04: begin state <= IGNORE; pend <= PEND_WRDI; end
                        default: state <= IGNORE;
                     endcase
                  end
               end
               ADDR_HI: begin
                  addr <= addr_shift;
                  if (bit_cnt == 3'd7) state <= ADDR_LO;
               end
               ADDR_LO: begin
                  addr <= addr_shift;
                  if (bit_cnt == 3'd7) state <= is_read ? DATA_RD : DATA_WR;
               end
               DATA_RD, DATA_WR: begin
                  if (bit_cnt == 3'd7) addr <= addr + ADDR_BITS'(1);
               end
               IGNORE: extra <= 1'b1;
               default: ;
            endcase
         end
         if (sclk_fall) begin
            if (state == DATA_RD || state == STATUS) begin
               if (bit_cnt == 3'd0) begin
                  miso_r <= load_byte[7];
                  tx_sr  <= {load_byte[6:0], 1'b0};
               end else begin
                  miso_r <= tx_sr[7];
                  tx_sr  <= {tx_sr[6:0], 1'b0};
               end
            end else begin
               miso_r <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/spi_fram_responder.md
SPI_FRAM_RESPONDER -- requirements
Module: spi_fram_responder

Interface
REQ-001 The block SHALL have one parameter: ADDR_BITS, default 10, the width of the internal byte-array address (depth 2^ADDR_BITS bytes).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 The block SHALL have the following ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- CS_N  in  1  SPI chip select, active low, asynchronous to clk
- CLK  in  1  SPI clock (mode 0), asynchronous to clk
- MOSI  in  1  SPI serial data in, MSB first
- MISO  out  1  SPI serial data out, MSB first
- miso_oe  out  1  MISO drive enable
- wel  out  1  write-enable latch state
- busy  out  1  high while a transaction is in progress

Function
REQ-004 CS_N, CLK and MOSI SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized CLK and CS_N.
REQ-005 The SPI clock SHALL be at most clk/8; the block need not operate above that rate.
REQ-006 MOSI SHALL be sampled on each detected CLK rise; MISO SHALL change only on a detected CLK fall or on a detected CS_N fall.
REQ-007 The FSM SHALL have the states IDLE, OPCODE, ADDR_HI, ADDR_LO, DATA_RD, DATA_WR, STATUS and IGNORE.
REQ-008 A synchronized CS_N fall SHALL move the FSM from IDLE to OPCODE and clear the bit counter.
REQ-009 After the 8th opcode bit is sampled, the FSM SHALL decode the opcode:
- 0x03 -> ADDR_HI (read)
- 0x02 -> ADDR_HI (write)
- 0x05 -> STATUS
- 0x06 -> IGNORE, with a pending WREN
- 0x04 -> IGNORE, with a pending WRDI
- any other value -> IGNORE
REQ-010 The address SHALL be 16 bits, sent MSB first across ADDR_HI and ADDR_LO; only the low ADDR_BITS bits SHALL be used.
REQ-011 After the 16th address bit is sampled:
- for a read, the FSM SHALL enter DATA_RD and start a synchronous memory read;
- for a write, it SHALL enter DATA_WR.
REQ-012 In DATA_RD, the read byte SHALL load the MISO shift register so that bit 7 appears at the next CLK fall.
REQ-013 In DATA_RD, each subsequent byte SHALL follow without gaps, the address SHALL increment after each byte, and the next byte SHALL be prefetched when bit 0 of the current byte is sampled.
REQ-014 In DATA_WR, each completed 8-bit byte SHALL be written to mem[addr] only if wel=1, then the address SHALL increment; when wel=0 the byte SHALL be discarded and the address SHALL still increment.
REQ-015 The address SHALL wrap from 2^ADDR_BITS-1 to 0 in both DATA_RD and DATA_WR.
REQ-016 In STATUS, MISO SHALL repeatedly shift out the byte {6'b0, wel, 1'b0} for as long as CS_N stays low.
REQ-017 In IGNORE and in the opcode/address phases, MISO SHALL be 0.
REQ-018 A synchronized CS_N rise SHALL return the FSM to IDLE from any state, and any partial byte SHALL be discarded.
REQ-019 On that CS_N rise:
- a pending WREN SHALL set wel only if exactly 8 bits were clocked;
- a pending WRDI SHALL clear wel only if exactly 8 bits were clocked;
- wel SHALL be cleared if a write transaction reached DATA_WR.
REQ-020 miso_oe SHALL equal the synchronized, inverted CS_N; busy SHALL be high in every state except IDLE.
REQ-021 CLK edges detected while the FSM is in IDLE SHALL be ignored.

Reset
REQ-022 When rst=1, the block SHALL, on the next clk edge, go to IDLE and drive MISO=0, miso_oe=0, wel=0 and busy=0.
REQ-023 Reset SHALL clear the synchronizers, the bit counter, the address and the shift registers.
REQ-024 Memory contents SHALL be left unchanged by reset.
REQ-025 When reset is asserted mid-transaction, the block SHALL remain in IDLE until the next CS_N fall after reset is released; that CS_N fall SHALL start the next transaction.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- WREN (0x06) then WRITE 0x02,0x0010,0xA5,0x5A, then READ 0x03,0x0010 for 2 bytes -> MISO returns 0xA5, 0x5A; wel=0 after the write ends.
- WRITE without a prior WREN -> READ returns the previous contents; wel stays 0.
- RDSR after WREN -> 0x02 repeated for 3 bytes; RDSR after WRDI -> 0x00.
- READ at address 0x03FF for 3 bytes after writing 0x11@0x3FF and 0x22@0x000 -> 0x11, 0x22, then mem[0x001].
- WRITE aborted by CS_N rising after 4 data bits -> the target byte is unchanged; WREN sent with 9 bits -> wel stays 0.
- rst asserted mid-read -> MISO=0, busy=0 on the next clk edge; a following READ behaves normally.
